// File: rtl/pipelined_cla_adder.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor.
// One GROUP-bit lookahead group per stage, valid/ready flow control.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = WIDTH / GROUP;

  typedef struct packed {
    logic [GROUP-1:0] s;
    logic             co;
    logic             cm;
  } grp_t;

  typedef struct packed {
    logic             v;
    logic             c;
    logic             ovf;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stg_t;

  // Carries are the fully expanded sum-of-products, not a ripple.
  function automatic grp_t cla_grp(
    input logic [GROUP-1:0] x,
    input logic [GROUP-1:0] y,
    input logic             c0
  );
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             pp;
    grp_t             r;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & c0);
    end
    r.s  = p ^ c[GROUP-1:0];
    r.co = c[GROUP];
    r.cm = c[GROUP-1];
    return r;
  endfunction

  stg_t head;
  stg_t src;
  grp_t res;
  stg_t stg_d [NSTG];
  stg_t stg_q [NSTG];
  logic advance;
  logic unused_tail;

  assign advance  = out_ready || !stg_q[NSTG-1].v;
  assign in_ready = advance;

  always_comb begin
    head   = '0;
    head.v = in_valid;
    head.a = a;
    head.b = sub ? ~b : b;
    head.c = sub | cin;
    src    = '0;
    res    = '0;
    stg_d  = '{default: '0};
    for (int k = 0; k < NSTG; k++) begin
      src = (k == 0) ? head : stg_q[(k == 0) ? 0 : k - 1];
      res = cla_grp(src.a[k*GROUP +: GROUP],
                    src.b[k*GROUP +: GROUP], src.c);
      stg_d[k]                      = src;
      stg_d[k].s[k*GROUP +: GROUP]  = res.s;
      stg_d[k].c                    = res.co;
      stg_d[k].ovf                  = res.co ^ res.cm;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_q <= '{default: '0};
    end else if (advance) begin
      stg_q <= stg_d;
    end
  end

  assign out_valid = stg_q[NSTG-1].v;
  assign sum       = stg_q[NSTG-1].s;
  assign cout      = stg_q[NSTG-1].c;
  assign ovf       = stg_q[NSTG-1].ovf;

  // Operand copies are fully consumed by the last stage.
  assign unused_tail = ^{stg_q[NSTG-1].a, stg_q[NSTG-1].b};

endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor. It generalises the team's 4-bit single-cycle CLA to WIDTH bits. The operand is split into GROUP-bit lookahead groups, with one pipeline stage per group and the group carry registered between stages. A valid/ready handshake on both sides carries full backpressure. The block sits in the datapath wherever a wide add or subtract must close timing at full clock rate.

## Interface
Parameters:
- WIDTH, default 16: operand and sum width; must be a multiple of GROUP.
- GROUP, default 4: bits per lookahead group. NSTG = WIDTH/GROUP stages.

Ports:
- clk  input  1: single clock; all state updates on the rising edge.
- rst_n  input  1: reset, synchronous and active-low.
- in_valid  input  1: operand beat present.
- in_ready  output  1: block accepts a beat this cycle.
- a  input  WIDTH: operand A.
- b  input  WIDTH: operand B.
- cin  input  1: carry-in; ignored when sub=1.
- sub  input  1: 0 computes A+B+cin; 1 computes A+~B+1 (A−B).
- out_valid  output  1: result beat present.
- out_ready  input  1: downstream accepts the result.
- sum  output  WIDTH: result, modulo 2^WIDTH.
- cout  output  1: carry out of the MSB. In subtract mode, 1 means no borrow.
- ovf  output  1: two's-complement overflow, equal to carry into the MSB XOR carry out of the MSB.

## Operation
- Accept: a beat is accepted when in_valid && in_ready. At accept, b is conditionally inverted and the effective carry-in is captured (cin, or 1 when sub=1).
- Stage k (k = 0..NSTG−1) performs:
  - Group generate/propagate (g_i = a_i & b_i, p_i = a_i ^ b_i) on bits [k*GROUP +: GROUP].
  - Fully expanded lookahead carries within the group, fed by the registered carry from stage k−1 (stage 0 uses the effective carry-in).
  - Group sum bits s_i = p_i ^ c_i.
- Skew alignment:
  - Upper operand groups not yet consumed travel down delay registers alongside the carry.
  - Finished lower sum groups travel down the same registers.
  - Each stage holds one valid bit.
- Result: the last stage's register drives sum, cout, ovf and out_valid directly. There is no combinational path from a/b to the outputs.
- Stall: global. advance = out_ready || !out_valid. When advance=0 every stage register holds, including valid bits. in_ready = advance.
- Bubbles propagate as valid=0. Data registers may update under a bubble, but outputs are only meaningful when out_valid=1.
- Ordering: strictly in order; no beat is dropped or duplicated.
- No state machine beyond the valid shift chain. All arithmetic is unsigned modulo 2^WIDTH; ovf is the signed interpretation.

## Timing
- Reset: rst_n sampled low at an edge clears all stage valid bits, out_valid, sum, cout and ovf to 0. After that edge in_ready = 1.
- Reset mid-operation: all in-flight beats are discarded. No partial result is ever presented.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NSTG−1 when there are no stalls. That is NSTG register stages, 4 cycles at the defaults.
- Throughput: one beat per cycle while out_ready=1.
- Simultaneous accept and output on the same edge is legal and required. A full pipeline with out_ready=1 accepts and retires every cycle.
- out_valid=1 with out_ready=0:
  - sum, cout and ovf hold stable until the handshake.
  - in_ready is 0 in that same cycle (combinational from out_ready and out_valid).
- in_valid=0 inserts a bubble. Later beats are not compacted while advance=1.
- Degenerate case GROUP=WIDTH: NSTG=1, a single-stage registered CLA with latency 1.

## Test plan
Defaults: WIDTH=16, GROUP=4.
- Basic add: a=0x1234, b=0x4321, cin=1, sub=0 → sum=0x5556, cout=0, ovf=0, out_valid high exactly 4 cycles after accept.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x8000, b=0x0001, sub=1, cin=1 (must be ignored) → sum=0x7FFF, cout=1, ovf=1. Then a=0x0003, b=0x0005, sub=1 → sum=0xFFFE, cout=0, ovf=0.
- Stream with backpressure: 10 back-to-back random beats; hold out_ready=0 for 3 cycles once out_valid rises → in_ready=0 during the stall, outputs stable, all 10 results correct and in order against a reference model, one result per cycle after release.
- Reset mid-stream: 3 beats in flight, drive rst_n=0 for one edge → out_valid=0, sum=0, cout=0, ovf=0 the next cycle. None of the 3 beats ever emerges, and a new beat after reset returns normally with latency 4.
- Parameter sweep: random add/sub with WIDTH/GROUP = 8/8, 32/4 and 32/8, compared against a+b+cin at WIDTH+1 bits → latency equals WIDTH/GROUP and the results match.
